// File: rtl/e203_dtcm_arbt.sv
// Two-port DTCM arbiter: round-robin grant between LSU (p0) and external bus (p1),
// one-cycle RAM read response with a hold register for stalled responses, idle light-sleep.
module e203_dtcm_arbt #(
  parameter int RAM_AW  = 14,
  parameter int DW      = 32,
  parameter int MW      = 4,
  parameter int LS_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_cmd_valid,
  output logic              p0_cmd_ready,
  input  logic              p0_cmd_read,
  input  logic [RAM_AW+1:0] p0_cmd_addr,
  input  logic [DW-1:0]     p0_cmd_wdata,
  input  logic [MW-1:0]     p0_cmd_wmask,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DW-1:0]     p0_rsp_rdata,
  input  logic              p1_cmd_valid,
  output logic              p1_cmd_ready,
  input  logic              p1_cmd_read,
  input  logic [RAM_AW+1:0] p1_cmd_addr,
  input  logic [DW-1:0]     p1_cmd_wdata,
  input  logic [MW-1:0]     p1_cmd_wmask,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DW-1:0]     p1_rsp_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_sd,
  output logic              ram_ds,
  output logic              ram_ls
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RSP  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [7:0] LS_MAX = 8'(LS_IDLE);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rd_q, rd_d;
  logic          rr_q, rr_d;
  logic [7:0]    idle_q, idle_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          any_vld_s;
  logic          own_rdy_s;
  logic          acc_s;
  logic          gnt_vld_s;
  logic          gnt_port_s;
  logic          gnt_read_s;
  logic [DW-1:0] rsp_data_s;

  assign ram_sd = 1'b0;
  assign ram_ds = 1'b0;
  assign ram_ls = (idle_q == LS_MAX);

  // Acceptance, grant selection and response data path.
  always_comb begin
    any_vld_s = p0_cmd_valid | p1_cmd_valid;
    own_rdy_s = owner_q ? p1_rsp_ready : p0_rsp_ready;
    // Waking from light sleep costs one cycle: nothing is accepted while ram_ls is high.
    acc_s     = !rst && !ram_ls && ((state_q == ST_IDLE) || own_rdy_s);
    gnt_vld_s = acc_s && any_vld_s;
    if (p0_cmd_valid && p1_cmd_valid) begin
      gnt_port_s = rr_q;
    end else begin
      gnt_port_s = p1_cmd_valid;
    end
    gnt_read_s = gnt_port_s ? p1_cmd_read : p0_cmd_read;
    if (state_q == ST_HOLD) begin
      rsp_data_s = hold_q;
    end else if (rd_q) begin
      rsp_data_s = ram_dout;
    end else begin
      rsp_data_s = '0;
    end
  end

  // Command-side and response-side outputs.
  always_comb begin
    p0_cmd_ready = gnt_vld_s && !gnt_port_s;
    p1_cmd_ready = gnt_vld_s && gnt_port_s;
    ram_cs       = gnt_vld_s;
    ram_we       = gnt_vld_s && !gnt_read_s;
    ram_addr     = gnt_port_s ? p1_cmd_addr[RAM_AW+1:2] : p0_cmd_addr[RAM_AW+1:2];
    ram_din      = gnt_port_s ? p1_cmd_wdata : p0_cmd_wdata;
    if (ram_we) begin
      ram_wem = gnt_port_s ? p1_cmd_wmask : p0_cmd_wmask;
    end else begin
      ram_wem = '0;
    end
    p0_rsp_valid = (state_q != ST_IDLE) && !owner_q;
    p1_rsp_valid = (state_q != ST_IDLE) && owner_q;
    p0_rsp_rdata = rsp_data_s;
    p1_rsp_rdata = rsp_data_s;
  end

  // Next-state: response FSM, ownership, round-robin pointer and idle counter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    idle_d  = idle_q;
    if (gnt_vld_s) begin
      state_d = ST_RSP;
      owner_d = gnt_port_s;
      rd_d    = gnt_read_s;
      rr_d    = !gnt_port_s;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_IDLE;
    end else if (own_rdy_s) begin
      state_d = ST_IDLE;
    end else begin
      // Stalled response: freeze the data so later ram_dout changes are not seen.
      state_d = ST_HOLD;
      hold_d  = rsp_data_s;
    end
    if (any_vld_s) begin
      idle_d = 8'd0;
    end else if ((state_q == ST_IDLE) && (idle_q != LS_MAX)) begin
      idle_d = idle_q + 8'd1;
    end else begin
      idle_d = idle_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      rr_q    <= 1'b0;
      idle_q  <= 8'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      rr_q    <= rr_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_e203_dtcm_arbt.sv
// Bench for e203_dtcm_arbt: behavioural RAM, response scoreboard and directed timing checks.
module tb_e203_dtcm_arbt;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          p0_cmd_valid, p0_cmd_ready, p0_cmd_read;
  logic [AW+1:0] p0_cmd_addr;
  logic [DW-1:0] p0_cmd_wdata;
  logic [MW-1:0] p0_cmd_wmask;
  logic          p0_rsp_valid, p0_rsp_ready;
  logic [DW-1:0] p0_rsp_rdata;
  logic          p1_cmd_valid, p1_cmd_ready, p1_cmd_read;
  logic [AW+1:0] p1_cmd_addr;
  logic [DW-1:0] p1_cmd_wdata;
  logic [MW-1:0] p1_cmd_wmask;
  logic          p1_rsp_valid, p1_rsp_ready;
  logic [DW-1:0] p1_rsp_rdata;
  logic          ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] model_dout = 32'h0;
  logic          dout_ovr = 1'b0;
  logic [DW-1:0] dout_junk = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] sb [$];
  int gnt_log [$];

  e203_dtcm_arbt dut (
    .clk(clk), .rst(rst),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready), .p0_cmd_read(p0_cmd_read),
    .p0_cmd_addr(p0_cmd_addr), .p0_cmd_wdata(p0_cmd_wdata), .p0_cmd_wmask(p0_cmd_wmask),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready), .p1_cmd_read(p1_cmd_read),
    .p1_cmd_addr(p1_cmd_addr), .p1_cmd_wdata(p1_cmd_wdata), .p1_cmd_wmask(p1_cmd_wmask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
  );

  always #5 clk = ~clk;

  // The override lets a stalled response see ram_dout wander.
  assign ram_dout = dout_ovr ? dout_junk : model_dout;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (ram_cs && !ram_we) model_dout <= mem[ram_addr[7:0]];
    if (ram_cs && ram_we) begin
      for (int b = 0; b < MW; b++) begin
        if (ram_wem[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  task automatic sb_grant(input logic port, input logic rd, input logic [AW+1:0] addr);
    check_eq("gnt_cs", ram_cs, 1'b1);
    check_eq("gnt_addr", ram_addr, addr[AW+1:2]);
    gnt_log.push_back(int'(port));
    if (rd) sb.push_back({port, mem[addr[9:2]]});
    else    sb.push_back({port, 32'h0});
  endtask

  task automatic sb_resp(input logic port, input logic [DW-1:0] data);
    logic [32:0] e;
    if (sb.size() == 0) begin
      check_eq("rsp_unexpected", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_eq("rsp_data", {port, data}, e);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rsp_excl", 64'(p0_rsp_valid & p1_rsp_valid), 64'd0);
      if (p0_rsp_valid && p0_rsp_ready) sb_resp(1'b0, p0_rsp_rdata);
      if (p1_rsp_valid && p1_rsp_ready) sb_resp(1'b1, p1_rsp_rdata);
      if (p0_cmd_valid && p0_cmd_ready) sb_grant(1'b0, p0_cmd_read, p0_cmd_addr);
      if (p1_cmd_valid && p1_cmd_ready) sb_grant(1'b1, p1_cmd_read, p1_cmd_addr);
    end
  end

  task automatic drive(input int port, input logic rd, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm);
    if (port == 0) begin
      p0_cmd_valid = 1'b1; p0_cmd_read = rd; p0_cmd_addr = addr;
      p0_cmd_wdata = wd; p0_cmd_wmask = wm;
    end else begin
      p1_cmd_valid = 1'b1; p1_cmd_read = rd; p1_cmd_addr = addr;
      p1_cmd_wdata = wd; p1_cmd_wmask = wm;
    end
  endtask

  task automatic idle_all();
    p0_cmd_valid = 1'b0;
    p1_cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hA5A5, 8'h00, 8'(i)};
    mem[4] = 32'hDEADBEEF;
    p1_cmd_valid = 1'b0; p1_cmd_read = 1'b1; p1_cmd_addr = 16'h0;
    p1_cmd_wdata = 32'h0; p1_cmd_wmask = 4'h0;
    drive(0, 1'b1, 16'h0000, 32'h0, 4'h0);
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;

    // Reset state, with a command already pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_p0_cmd_ready", p0_cmd_ready, 1'b0);
    check_eq("rst_ram_cs", ram_cs, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
    check_eq("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
    check_eq("rst_ram_ls", ram_ls, 1'b0);
    check_eq("ram_sd_ds", {ram_sd, ram_ds}, 2'b00);

    // Read latency: grant in the first cycle after reset, data one cycle later.
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("rd_cs", ram_cs, 1'b1);
    check_eq("rd_addr", ram_addr, 14'd4);
    check_eq("rd_p0_ready", p0_cmd_ready, 1'b1);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    check_eq("rd_rsp_valid", p0_rsp_valid, 1'b1);
    check_eq("rd_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);

    // Masked write, zero response data, then read-back from the other port.
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0020, 32'h11223344, 4'h3);
    @(negedge clk);
    check_eq("wr_we", ram_we, 1'b1);
    check_eq("wr_wem", ram_wem, 4'h3);
    check_eq("wr_din", ram_din, 32'h11223344);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    check_eq("wr_rsp_valid", p0_rsp_valid, 1'b1);
    check_eq("wr_rsp_rdata", p0_rsp_rdata, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 16'h0020, 32'h0, 4'h0);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    check_eq("rb_rdata", p1_rsp_rdata, 32'hA5A53344);

    // Both ports continuously valid: strict alternation, one grant per cycle.
    @(posedge clk); #1;
    gnt_log.delete();
    drive(0, 1'b1, 16'h0040, 32'h0, 4'h0);
    drive(1, 1'b1, 16'h0044, 32'h0, 4'h0);
    repeat (6) @(posedge clk);
    #1;
    idle_all();
    @(negedge clk);
    check_eq("alt_count", gnt_log.size(), 6);
    for (int i = 0; i < gnt_log.size(); i++) check_eq("alt_port", gnt_log[i], i % 2);

    // Stalled p1 response holds its data; pending p0 waits for the handshake cycle.
    @(posedge clk); #1;
    drive(1, 1'b1, 16'h0030, 32'h0, 4'h0);
    p1_rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("hold_gnt", p1_cmd_ready, 1'b1);
    @(posedge clk); #1;
    p1_cmd_valid = 1'b0;
    drive(0, 1'b0, 16'h0050, 32'hCAFEF00D, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("hold_valid", p1_rsp_valid, 1'b1);
      check_eq("hold_rdata", p1_rsp_rdata, 32'hA5A5000C);
      check_eq("hold_no_gnt", p0_cmd_ready, 1'b0);
      @(posedge clk); #1;
      dout_ovr  = 1'b1;
      dout_junk = 32'h12345678 + 32'(c);
    end
    p1_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_hs_rdata", p1_rsp_rdata, 32'hA5A5000C);
    check_eq("hold_b2b_gnt", p0_cmd_ready, 1'b1);
    @(posedge clk); #1;
    idle_all();
    dout_ovr = 1'b0;
    @(negedge clk);
    check_eq("b2b_rsp_valid", p0_rsp_valid, 1'b1);

    // Light sleep after LS_IDLE idle cycles, with one-cycle wake-up.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("ls_off", ram_ls, 1'b0);
    end
    @(posedge clk); #1;
    drive(1, 1'b1, 16'h0060, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("ls_on", ram_ls, 1'b1);
    check_eq("wake_no_ready", p1_cmd_ready, 1'b0);
    check_eq("wake_no_cs", ram_cs, 1'b0);
    @(negedge clk);
    check_eq("ls_woke", ram_ls, 1'b0);
    check_eq("wake_ready", p1_cmd_ready, 1'b1);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);

    // Asynchronous reset while a response is held.
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h0010, 32'h0, 4'h0);
    p0_rsp_ready = 1'b0;
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    check_eq("pre_rst_valid", p0_rsp_valid, 1'b1);
    @(posedge clk); #2;
    check_eq("hold_pre_rst_valid", p0_rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", p0_rsp_valid, 1'b0);
    sb.delete();
    p0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1'b1, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("post_rst_p0_valid", p0_rsp_valid, 1'b0);
    check_eq("post_rst_p1_valid", p1_rsp_valid, 1'b0);
    check_eq("post_rst_gnt", p1_cmd_ready, 1'b1);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    check_eq("post_rst_rdata", p1_rsp_rdata, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
